manual_drive_fsm: RTL and testbench

Manual-driving state machine for the car simulator. Converts the driver's debounced switch/button levels (power, clutch, throttle, brake, reverse gear, turn buttons) into registered motion commands, a power/engine state and a mileage count. Sits directly upstream of `SimulatedDevice`, which packs these commands into UART frames for the simulator.

---
 rtl/manual_drive_fsm.sv | 141 ++++++++++++++
 tb/tb_manual_drive_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manual_drive_fsm.sv
// Manual-driving state machine for the car simulator: turns debounced driver
// controls into registered motion/steering commands, power state and mileage.
module manual_drive_fsm #(
    parameter int POWER_ON_CYCLES = 100_000_000,
    parameter int MILE_CYCLES     = 100_000_000,
    parameter int MILE_W          = 24
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              power_on,
    input  logic              power_off,
    input  logic              mode_manual,
    input  logic              clutch,
    input  logic              throttle,
    input  logic              brake,
    input  logic              reverse,
    input  logic              bu_left,
    input  logic              bu_right,
    output logic [1:0]        state,
    output logic              powered,
    output logic              move_forward,
    output logic              move_backward,
    output logic              turn_left,
    output logic              turn_right,
    output logic              stall,
    output logic [MILE_W-1:0] mileage
);

    localparam int PW = (POWER_ON_CYCLES > 1) ? $clog2(POWER_ON_CYCLES) : 1;
    localparam int MW = (MILE_CYCLES > 1) ? $clog2(MILE_CYCLES) : 1;

    typedef enum logic [1:0] {
        OFF       = 2'b00,
        NOT_START = 2'b01,
        STARTING  = 2'b10,
        MOVING    = 2'b11
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            stall_d;
    logic            gear_q;
    logic            gear_change;
    logic [PW-1:0]   power_cnt;
    logic [MW-1:0]   mile_pre;

    assign state = state_q;

    // Shifting gear without the clutch while the engine runs kills the engine.
    assign gear_change = (reverse != gear_q) && !clutch &&
                         (state_q == STARTING || state_q == MOVING);

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        if (power_off) begin
            state_d = OFF;
        end else if (mode_manual) begin
            case (state_q)
                OFF: begin
                    if (power_on && power_cnt == PW'(POWER_ON_CYCLES - 1))
                        state_d = NOT_START;
                end
                NOT_START: begin
                    if (!brake && throttle) begin
                        if (clutch) begin
                            state_d = STARTING;
                        end else begin
                            state_d = OFF;
                            stall_d = 1'b1;
                        end
                    end
                end
                STARTING: begin
                    if (gear_change) begin
                        state_d = OFF;
                        stall_d = 1'b1;
                    end else if (brake) begin
                        state_d = NOT_START;
                    end else if (throttle && !clutch) begin
                        state_d = MOVING;
                    end
                end
                MOVING: begin
                    if (gear_change) begin
                        state_d = OFF;
                        stall_d = 1'b1;
                    end else if (brake) begin
                        state_d = NOT_START;
                    end else if (!throttle || clutch) begin
                        state_d = STARTING;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Outputs are registered from the next-state value so they line up with state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= OFF;
            stall         <= 1'b0;
            powered       <= 1'b0;
            gear_q        <= 1'b0;
            move_forward  <= 1'b0;
            move_backward <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
            power_cnt     <= '0;
            mile_pre      <= '0;
            mileage       <= '0;
        end else begin
            state_q       <= state_d;
            stall         <= stall_d;
            powered       <= (state_d != OFF);
            gear_q        <= reverse;
            move_forward  <= mode_manual && (state_d == MOVING) && !reverse;
            move_backward <= mode_manual && (state_d == MOVING) && reverse;
            turn_left     <= mode_manual && (state_d != OFF) && bu_left && !bu_right;
            turn_right    <= mode_manual && (state_d != OFF) && bu_right && !bu_left;

            if (state_q == OFF && state_d == OFF && mode_manual && !power_off && power_on)
                power_cnt <= power_cnt + 1'b1;
            else
                power_cnt <= '0;

            // Prescaler only advances while actually driving; it pauses otherwise.
            if (state_q == MOVING && mode_manual) begin
                if (mile_pre == MW'(MILE_CYCLES - 1)) begin
                    mile_pre <= '0;
                    if (mileage != '1)
                        mileage <= mileage + 1'b1;
                end else begin
                    mile_pre <= mile_pre + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_manual_drive_fsm.sv
// Self-checking bench for manual_drive_fsm: directed scenarios with literal
// expectations plus randomized driving checked against a behavioural model.
module tb_manual_drive_fsm;

    localparam int P = 4;
    localparam int M = 8;
    localparam int W = 4;
    localparam int MILE_MAX = (1 << W) - 1;

    logic         sys_clk;
    logic         rst;
    logic         power_on, power_off, mode_manual;
    logic         clutch, throttle, brake, reverse;
    logic         bu_left, bu_right;
    logic [1:0]   state;
    logic         powered, move_forward, move_backward;
    logic         turn_left, turn_right, stall;
    logic [W-1:0] mileage;

    int n_cmp  = 0;
    int n_fail = 0;

    manual_drive_fsm #(
        .POWER_ON_CYCLES(P),
        .MILE_CYCLES    (M),
        .MILE_W         (W)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .power_on     (power_on),
        .power_off    (power_off),
        .mode_manual  (mode_manual),
        .clutch       (clutch),
        .throttle     (throttle),
        .brake        (brake),
        .reverse      (reverse),
        .bu_left      (bu_left),
        .bu_right     (bu_right),
        .state        (state),
        .powered      (powered),
        .move_forward (move_forward),
        .move_backward(move_backward),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .stall        (stall),
        .mileage      (mileage)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural model: state as an integer 0..3, counters as plain ints.
    int m_state, m_cnt, m_pre, m_mile, ns;
    bit m_gear, m_valid, st, gchg;
    bit e_powered, e_fwd, e_bwd, e_tl, e_tr, e_stall;

    initial m_valid = 1'b0;

    always @(posedge sys_clk) begin
        if (rst) begin
            m_state = 0; m_cnt = 0; m_pre = 0; m_mile = 0; m_gear = 1'b0;
            e_powered = 0; e_fwd = 0; e_bwd = 0; e_tl = 0; e_tr = 0; e_stall = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ns = m_state;
            st = 1'b0;
            gchg = (reverse != m_gear) && !clutch && (m_state >= 2);
            if (power_off) begin
                ns = 0;
                m_cnt = 0;
            end else if (!mode_manual) begin
                m_cnt = 0;
            end else begin
                case (m_state)
                    0: begin
                        if (power_on) begin
                            m_cnt++;
                            if (m_cnt == P) begin ns = 1; m_cnt = 0; end
                        end else begin
                            m_cnt = 0;
                        end
                    end
                    1: if (!brake && throttle) begin
                        if (clutch) ns = 2;
                        else begin ns = 0; st = 1'b1; end
                    end
                    2: begin
                        if (gchg) begin ns = 0; st = 1'b1; end
                        else if (brake) ns = 1;
                        else if (throttle && !clutch) ns = 3;
                    end
                    default: begin
                        if (gchg) begin ns = 0; st = 1'b1; end
                        else if (brake) ns = 1;
                        else if (!throttle || clutch) ns = 2;
                    end
                endcase
            end
            if (m_state == 3 && mode_manual) begin
                m_pre++;
                if (m_pre == M) begin
                    m_pre = 0;
                    if (m_mile < MILE_MAX) m_mile++;
                end
            end
            m_state   = ns;
            e_stall   = st;
            e_powered = (ns != 0);
            e_fwd     = mode_manual && ns == 3 && !reverse;
            e_bwd     = mode_manual && ns == 3 && reverse;
            e_tl      = mode_manual && ns != 0 && bu_left && !bu_right;
            e_tr      = mode_manual && ns != 0 && bu_right && !bu_left;
            m_gear    = reverse;
        end
        #1;
        if (m_valid) begin
            n_cmp++;
            if (state !== 2'(m_state)) begin
                n_fail++;
                $display("[TB] FAIL model_state t=%0t actual=%0d required=%0d", $time, state, m_state);
            end
            n_cmp++;
            if ({powered, move_forward, move_backward, turn_left, turn_right, stall} !==
                {e_powered, e_fwd, e_bwd, e_tl, e_tr, e_stall}) begin
                n_fail++;
                $display("[TB] FAIL model_flags t=%0t actual=%b required=%b (pwr fwd bwd tl tr stall)", $time,
                         {powered, move_forward, move_backward, turn_left, turn_right, stall},
                         {e_powered, e_fwd, e_bwd, e_tl, e_tr, e_stall});
            end
            n_cmp++;
            if (mileage !== W'(m_mile)) begin
                n_fail++;
                $display("[TB] FAIL model_mileage t=%0t actual=%0d required=%0d", $time, mileage, m_mile);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic powerUp();
        power_on = 1'b1;
        tick(P);
        power_on = 1'b0;
    endtask

    task automatic driveToMoving();
        clutch = 1'b1; throttle = 1'b1;
        tick();
        clutch = 1'b0;
        tick();
    endtask

    task automatic applyStimulus();
        rst         = ($urandom_range(0, 299) == 0);
        power_off   = ($urandom_range(0, 79) == 0);
        mode_manual = ($urandom_range(0, 19) != 0);
        power_on    = ($urandom_range(0, 3) != 0);
        throttle    = $urandom_range(0, 1) == 1;
        clutch      = $urandom_range(0, 1) == 1;
        brake       = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 9) == 0) reverse = ~reverse;
        bu_left     = $urandom_range(0, 1) == 1;
        bu_right    = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        rst = 1'b1; power_on = 0; power_off = 0; mode_manual = 1'b1;
        clutch = 0; throttle = 0; brake = 0; reverse = 0; bu_left = 0; bu_right = 0;
        tick(2);
        rst = 1'b0;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_powered", powered, 0);
        checkOutput("reset_mileage", mileage, 0);

        power_on = 1'b1;
        tick(3);
        checkOutput("power_3_edges", state, 0);
        tick();
        checkOutput("power_4_edges", state, 1);
        checkOutput("powered_high", powered, 1);
        power_on = 1'b0;

        clutch = 1'b1; throttle = 1'b1;
        tick();
        checkOutput("to_starting", state, 2);
        clutch = 1'b0;
        tick();
        checkOutput("to_moving", state, 3);
        checkOutput("fwd_on", move_forward, 1);
        brake = 1'b1;
        tick();
        checkOutput("brake_not_start", state, 1);
        checkOutput("fwd_off", move_forward, 0);
        brake = 1'b0; throttle = 1'b0;

        throttle = 1'b1; brake = 1'b1;
        tick();
        checkOutput("brake_blocks_stall", state, 1);
        brake = 1'b0;
        tick();
        checkOutput("ns_stall_state", state, 0);
        checkOutput("ns_stall_pulse", stall, 1);
        throttle = 1'b0;
        tick();
        checkOutput("stall_one_cycle", stall, 0);

        power_on = 1'b1;
        tick(3);
        power_on = 1'b0;
        tick();
        checkOutput("short_press", state, 0);

        powerUp();
        checkOutput("repower", state, 1);
        driveToMoving();
        reverse = 1'b1;
        tick();
        checkOutput("gear_stall_state", state, 0);
        checkOutput("gear_stall_pulse", stall, 1);
        reverse = 1'b0; throttle = 1'b0;
        tick();

        powerUp();
        clutch = 1'b1; throttle = 1'b1;
        tick();
        reverse = 1'b1;
        tick();
        checkOutput("clutch_shift_state", state, 2);
        checkOutput("clutch_shift_nostall", stall, 0);
        clutch = 1'b0;
        tick();
        checkOutput("rev_moving", state, 3);
        checkOutput("bwd_on", move_backward, 1);

        bu_left = 1'b1;
        tick();
        checkOutput("turn_left_on", turn_left, 1);
        bu_right = 1'b1;
        tick();
        checkOutput("both_buttons", {turn_left, turn_right}, 0);
        bu_left = 1'b0;
        tick();
        checkOutput("turn_right_on", turn_right, 1);
        bu_right = 1'b0;

        mode_manual = 1'b0;
        tick();
        checkOutput("auto_frozen_state", state, 3);
        checkOutput("auto_no_motion", move_backward, 0);
        throttle = 1'b0;
        tick();
        checkOutput("auto_still_frozen", state, 3);
        mode_manual = 1'b1;
        tick();
        checkOutput("resume_starting", state, 2);

        power_on = 1'b1; power_off = 1'b1;
        tick(2);
        checkOutput("on_off_together", state, 0);
        power_off = 1'b0;
        tick(3);
        checkOutput("cnt_held_zero", state, 0);
        tick();
        checkOutput("power_after_off", state, 1);
        power_on = 1'b0; reverse = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        powerUp();
        driveToMoving();
        tick(24);
        checkOutput("mileage_24", mileage, 3);
        brake = 1'b1;
        tick();
        brake = 1'b0; throttle = 1'b0; power_off = 1'b1;
        tick();
        power_off = 1'b0;
        checkOutput("off_state", state, 0);
        checkOutput("mileage_kept_off", mileage, 3);
        powerUp();
        checkOutput("mileage_kept_on", mileage, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mileage_rst", mileage, 0);

        powerUp();
        driveToMoving();
        tick(MILE_MAX * M + 16);
        checkOutput("mileage_saturated", mileage, MILE_MAX);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
